fail_logger: RTL and testbench
==============================

Name: fail_logger

Overview:
- Downstream of the data comparator in the PMBIST datapath.
- Consumes the per-read pass/fail result together with the address, expected data and march element index of that read.
- Keeps a sticky fail flag and a saturating fail counter.
- Buffers the first failing reads in a small FIFO, which the BIST controller or debug port drains over a valid/ready interface.

Parameters:
- dw, `DATA_WIDTH, width of expected-data field stored per fail
- aw, `ADDR_WIDTH, width of failing address field
- DEPTH, 4, number of log entries (power of 2, >= 2)
- CW, 16, fail counter width
- PW, 4, march element/phase index width

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- test_start  in  1  synchronous clear of all state at the start of a test run
- cmp_valid  in  1  comparator result valid this cycle (one per memory read)
- cmp_fail  in  1  comparator result, 1 = mismatch; ignored when cmp_valid = 0
- cmp_addr  in  aw  address of the compared read
- cmp_data  in  dw  expected (BIST) data of the compared read
- cmp_phase  in  PW  march element index of the compared read
- fail_sticky  out  1  at least one fail since reset/test_start
- fail_count  out  CW  number of fails, saturating
- log_valid  out  1  log head entry available
- log_ready  in  1  consumer accepts the head entry
- log_addr  out  aw  head entry address
- log_data  out  dw  head entry expected data
- log_phase  out  PW  head entry phase
- log_level  out  $clog2(DEPTH)+1  current number of entries
- log_overflow  out  1  sticky, at least one fail was dropped because the log was full

Behaviour:
- Reset (rst_n low, async):
  - fail_sticky = 0, fail_count = 0, log_valid = 0, log_level = 0, log_overflow = 0.
  - log_addr, log_data and log_phase = 0; FIFO pointers = 0.
- test_start = 1:
  - Same clear as reset, applied at the clock edge.
  - Has priority over a capture or a pop in the same cycle; that capture is discarded and not counted.
- Capture event: cmp_valid & cmp_fail & ~test_start.
- On a capture event:
  - fail_sticky is 1 from the next cycle.
  - fail_count increments by 1 unless it is already 2^CW-1, where it holds.
- Pop event: log_valid & log_ready.
  - Head advances at the edge; the next entry or log_valid = 0 is visible in the following cycle.
  - log_ready while log_valid = 0 has no effect.
- Write: a capture event writes {cmp_addr, cmp_data, cmp_phase} at the tail when log_level < DEPTH.
- Full and capture, no pop: entry dropped, log_overflow set, fail_count still increments.
- Full, capture and pop in the same cycle: both happen; level stays DEPTH; no overflow.
- Empty and capture: entry visible on log_* with log_valid = 1 one cycle later (1-cycle latency). No combinational bypass from cmp_* to log_*.
- Simultaneous push and pop at a non-zero level: level unchanged; order preserved (FIFO).
- Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full/empty is decided by the MSB and the equality of the remaining bits.
- log_* fields are stable while log_valid = 1 and log_ready = 0.
- Passing reads (cmp_fail = 0) and cycles with cmp_valid = 0 change nothing.
- Outputs are registered, except that log_addr, log_data and log_phase may be a registered-pointer memory read.

Decomposition:
- Shared constants in defines.v: `DATA_WIDTH, `ADDR_WIDTH, plus new `FAIL_LOG_DEPTH, `FAIL_CNT_WIDTH, `PHASE_WIDTH, used as parameter defaults.
- One sub-module: fail_log_fifo, a generic synchronous FIFO (width, depth) with push, pop, full, empty, level.
- The fail_logger top holds the sticky flag, the counter, overflow logic and the test_start priority.

Test Plan:
- Reset, then 10 passing reads (cmp_valid = 1, cmp_fail = 0) -> fail_sticky = 0, fail_count = 0, log_valid = 0 throughout.
- Single fail at addr 0x1A, data 0x55, phase 2 -> next cycle fail_sticky = 1, fail_count = 1, log_valid = 1, log_addr = 0x1A, log_data = 0x55, log_phase = 2. Pop -> log_valid = 0.
- 6 fails at addrs 1..6, log_ready = 0, DEPTH = 4 -> log_level = 4, log_overflow = 1, fail_count = 6. Drain pops addrs 1, 2, 3, 4 in order.
- Log full (4 entries) with capture of addr 9 and pop in the same cycle -> level stays 4, no overflow. Drain order is 2, 3, 4, 9.
- CW = 4, 20 fails -> fail_count saturates at 15.
- test_start asserted in the same cycle as a fail -> all outputs 0 next cycle, the fail is not logged. Async rst_n mid-drain -> immediate clear.

Source files
------------

// File: rtl/fail_logger_pkg.sv
// Shared widths and helpers for the PMBIST fail logger slice.
// Constants here serve as the parameter defaults of the logger and its FIFO.
package fail_logger_pkg;

   localparam int DATA_WIDTH     = 8;
   localparam int ADDR_WIDTH     = 8;
   localparam int FAIL_LOG_DEPTH = 4;
   localparam int FAIL_CNT_WIDTH = 16;
   localparam int PHASE_WIDTH    = 4;

   // Pointer width: one extra bit beyond the index so full and empty are distinguishable.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fail_log_fifo.sv
// Generic synchronous FIFO with registered full/empty/level flags.
// Head data is a memory read at the registered read pointer, forced to zero when empty.
module fail_log_fifo
   import fail_logger_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = FAIL_LOG_DEPTH
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clr,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             din,
   output logic [WIDTH-1:0]             dout,
   output logic                         full,
   output logic                         empty,
   output logic [ptr_width(DEPTH)-1:0]  level
);

   localparam int PTRW = ptr_width(DEPTH);
   localparam int IW   = PTRW - 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTRW-1:0]  wr_ptr, rd_ptr, wr_nxt, rd_nxt;
   logic             do_push, do_pop;

   // A push into a full FIFO is accepted when the head leaves at the same edge.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      wr_nxt = wr_ptr + {{IW{1'b0}}, do_push};
      rd_nxt = rd_ptr + {{IW{1'b0}}, do_pop};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
         level  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
         level  <= '0;
      end else begin
         wr_ptr <= wr_nxt;
         rd_ptr <= rd_nxt;
         empty  <= (wr_nxt == rd_nxt);
         full   <= (wr_nxt[IW] != rd_nxt[IW]) && (wr_nxt[IW-1:0] == rd_nxt[IW-1:0]);
         level  <= wr_nxt - rd_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clr)
         mem[wr_ptr[IW-1:0]] <= din;
   end

   assign dout = empty ? '0 : mem[rd_ptr[IW-1:0]];

endmodule

// File: rtl/fail_logger.sv
// Fail logger: sticky fail flag, saturating fail counter and a FIFO of the first failing reads.
// test_start clears everything synchronously and overrides any capture or pop in that cycle.
module fail_logger
   import fail_logger_pkg::*;
#(
   parameter int dw    = DATA_WIDTH,
   parameter int aw    = ADDR_WIDTH,
   parameter int DEPTH = FAIL_LOG_DEPTH,
   parameter int CW    = FAIL_CNT_WIDTH,
   parameter int PW    = PHASE_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       test_start,
   input  logic                       cmp_valid,
   input  logic                       cmp_fail,
   input  logic [aw-1:0]              cmp_addr,
   input  logic [dw-1:0]              cmp_data,
   input  logic [PW-1:0]              cmp_phase,
   output logic                       fail_sticky,
   output logic [CW-1:0]              fail_count,
   output logic                       log_valid,
   input  logic                       log_ready,
   output logic [aw-1:0]              log_addr,
   output logic [dw-1:0]              log_data,
   output logic [PW-1:0]              log_phase,
   output logic [$clog2(DEPTH):0]     log_level,
   output logic                       log_overflow
);

   localparam int EW = aw + dw + PW;

   logic          capture, pop_req, full, empty;
   logic [EW-1:0] head;

   assign capture = cmp_valid & cmp_fail & ~test_start;
   assign pop_req = log_ready & ~test_start;

   fail_log_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (test_start),
      .push  (capture),
      .pop   (pop_req),
      .din   ({cmp_addr, cmp_data, cmp_phase}),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .level (log_level)
   );

   assign log_valid = ~empty;
   assign {log_addr, log_data, log_phase} = head;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail_sticky  <= 1'b0;
         fail_count   <= '0;
         log_overflow <= 1'b0;
      end else if (test_start) begin
         fail_sticky  <= 1'b0;
         fail_count   <= '0;
         log_overflow <= 1'b0;
      end else if (capture) begin
         fail_sticky <= 1'b1;
         if (fail_count != '1)
            fail_count <= fail_count + {{(CW-1){1'b0}}, 1'b1};
         // Full implies a valid head, so log_ready alone means the head leaves this edge.
         if (full && !log_ready)
            log_overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fail_logger.sv
// Directed bench for fail_logger with a queue-based scoreboard of expected log entries.
module tb_fail_logger;

   localparam int DW = 8, AW = 8, DEPTH = 4, CW = 4, PW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          test_start = 1'b0;
   logic          cmp_valid = 1'b0;
   logic          cmp_fail = 1'b0;
   logic [AW-1:0] cmp_addr = '0;
   logic [DW-1:0] cmp_data = '0;
   logic [PW-1:0] cmp_phase = '0;
   logic          log_ready = 1'b0;
   logic          fail_sticky, log_valid, log_overflow;
   logic [CW-1:0] fail_count;
   logic [AW-1:0] log_addr;
   logic [DW-1:0] log_data;
   logic [PW-1:0] log_phase;
   logic [2:0]    log_level;

   fail_logger #(.dw(DW), .aw(AW), .DEPTH(DEPTH), .CW(CW), .PW(PW)) dut (
      .clk(clk), .rst_n(rst_n), .test_start(test_start),
      .cmp_valid(cmp_valid), .cmp_fail(cmp_fail), .cmp_addr(cmp_addr),
      .cmp_data(cmp_data), .cmp_phase(cmp_phase),
      .fail_sticky(fail_sticky), .fail_count(fail_count),
      .log_valid(log_valid), .log_ready(log_ready),
      .log_addr(log_addr), .log_data(log_data), .log_phase(log_phase),
      .log_level(log_level), .log_overflow(log_overflow)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   // Reference model state
   bit                 m_sticky, m_ovf, m_clean;
   int                 m_cnt;
   logic [AW+DW+PW-1:0] sb[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_sticky = 0; m_ovf = 0; m_cnt = 0; m_clean = 1;
      sb.delete();
   endtask

   task automatic check_outputs(input string tag);
      logic [AW+DW+PW-1:0] e;
      chk({tag, ".sticky"},   32'(fail_sticky),  32'(m_sticky));
      chk({tag, ".count"},    32'(fail_count),   32'(m_cnt));
      chk({tag, ".valid"},    32'(log_valid),    32'(sb.size() != 0));
      chk({tag, ".level"},    32'(log_level),    32'(sb.size()));
      chk({tag, ".overflow"}, 32'(log_overflow), 32'(m_ovf));
      if (sb.size() != 0 || m_clean) begin
         e = (sb.size() != 0) ? sb[0] : '0;
         chk({tag, ".addr"},  32'(log_addr),  32'(e[AW+DW+PW-1:DW+PW]));
         chk({tag, ".data"},  32'(log_data),  32'(e[DW+PW-1:PW]));
         chk({tag, ".phase"}, 32'(log_phase), 32'(e[PW-1:0]));
      end
   endtask

   task automatic step(input string tag, input bit v, input bit f, input logic [7:0] a,
                       input bit rdy, input bit ts);
      bit pop, cap;
      logic [7:0] d;
      @(negedge clk);
      d = a ^ 8'hA5;
      cmp_valid = v; cmp_fail = f; cmp_addr = a; cmp_data = d;
      cmp_phase = a[3:0]; log_ready = rdy; test_start = ts;
      if (ts) model_clear();
      else begin
         pop = (sb.size() != 0) && rdy;
         cap = v && f;
         if (pop) void'(sb.pop_front());
         if (cap) begin
            m_sticky = 1;
            if (m_cnt != (1 << CW) - 1) m_cnt++;
            if (sb.size() < DEPTH) begin
               sb.push_back({a, d, a[3:0]});
               m_clean = 0;
            end else m_ovf = 1;
         end
      end
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   initial begin
      model_clear();
      // Reset held across a few edges
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) step("pass_read", 1, 0, 8'(i + 8'h30), 0, 0);
      step("idle_fail", 0, 1, 8'h77, 0, 0);

      // Single fail at 0x1A (data 0x1A^0xA5 used for every entry; spot value below)
      @(negedge clk);
      cmp_valid = 1; cmp_fail = 1; cmp_addr = 8'h1A; cmp_data = 8'h55; cmp_phase = 4'd2;
      log_ready = 0; test_start = 0;
      m_sticky = 1; m_cnt++; sb.push_back({8'h1A, 8'h55, 4'd2}); m_clean = 0;
      @(posedge clk); #1;
      check_outputs("single_fail");
      step("single_pop", 0, 0, 8'h00, 1, 0);
      step("ready_empty", 0, 0, 8'h00, 1, 0);

      // Overflow: 6 fails into a 4-deep log
      step("clear1", 0, 0, 8'h00, 0, 1);
      for (int i = 1; i <= 6; i++) step("fill_ovf", 1, 1, 8'(i), 0, 0);
      chk("ovf_count_6", 32'(fail_count), 32'd6);
      for (int i = 1; i <= 4; i++) step("drain_ovf", 0, 0, 8'h00, 1, 0);

      // Full with simultaneous capture and pop
      step("clear2", 0, 0, 8'h00, 0, 1);
      for (int i = 1; i <= 4; i++) step("fill_full", 1, 1, 8'(i), 0, 0);
      step("full_cap_pop", 1, 1, 8'h09, 1, 0);
      for (int i = 0; i < 4; i++) step("drain_full", 0, 0, 8'h00, 1, 0);

      // Push and pop together at a non-zero level
      step("mid_a", 1, 1, 8'h41, 0, 0);
      step("mid_b", 1, 1, 8'h42, 0, 0);
      step("mid_push_pop", 1, 1, 8'h43, 1, 0);
      step("mid_stall", 0, 0, 8'h00, 0, 0);
      for (int i = 0; i < 3; i++) step("mid_drain", 0, 0, 8'h00, 1, 0);

      // Counter saturation with CW = 4
      step("clear3", 0, 0, 8'h00, 0, 1);
      for (int i = 0; i < 20; i++) step("saturate", 1, 1, 8'(8'h80 + i), 0, 0);
      chk("sat_count_15", 32'(fail_count), 32'd15);

      // test_start beats a same-cycle fail and pop
      step("ts_fail", 1, 1, 8'h5C, 1, 1);
      step("after_ts", 0, 0, 8'h00, 0, 0);

      // Asynchronous reset in the middle of a drain
      step("pre_rst_a", 1, 1, 8'h61, 0, 0);
      step("pre_rst_b", 1, 1, 8'h62, 0, 0);
      step("pre_rst_c", 1, 1, 8'h63, 0, 0);
      step("pre_rst_pop", 0, 0, 8'h00, 1, 0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      model_clear();
      check_outputs("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      log_ready = 0;
      step("post_rst", 1, 1, 8'h24, 0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
